// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB + 2-bit PHT branch predictor; optional gshare indexing under BP_GSHARE_EN
module branch_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_pc,
   output logic        pred_valid,
   output logic        predicted_outcome,
   output logic [31:0] predicted_target,
   output logic        pred_hit,
   input  logic        update_btb,
   input  logic [31:0] update_pc,
   input  logic        branch_outcome,
   input  logic [31:0] branch_target,
   input  logic        miss,
   output logic [15:0] miss_count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic              btb_valid_q [ENTRIES];
   logic [TAG_W-1:0]  btb_tag_q   [ENTRIES];
   logic [31:0]       btb_tgt_q   [ENTRIES];
   logic [1:0]        pht_q       [ENTRIES];

   logic [IDX_W-1:0]  f_idx, f_pidx, u_idx, u_pidx;
   logic [TAG_W-1:0]  f_tag, u_tag;
   logic              f_hit, u_hit;
   logic [1:0]        u_cnt, u_cnt_d;

   logic              pred_valid_q, pred_valid_d;
   logic              pred_hit_q, pred_hit_d;
   logic              pred_out_q, pred_out_d;
   logic [31:0]       pred_tgt_q, pred_tgt_d;
   logic [15:0]       miss_count_q, miss_count_d;

   logic              unused_pc_bits;

   assign f_idx = fetch_pc[IDX_W+1:2];
   assign f_tag = fetch_pc[31:IDX_W+2];
   assign u_idx = update_pc[IDX_W+1:2];
   assign u_tag = update_pc[31:IDX_W+2];
   assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

`ifdef BP_GSHARE_EN
   logic [3:0]       ghr_q, ghr_d;
   logic [IDX_W+3:0] ghr_ext;

   // Zero-extend then truncate so any IDX_W (including < 4) folds correctly.
   assign ghr_ext = {{IDX_W{1'b0}}, ghr_q};
   assign f_pidx  = f_idx ^ ghr_ext[IDX_W-1:0];
   assign u_pidx  = u_idx ^ ghr_ext[IDX_W-1:0];

   always_comb begin
      ghr_d = ghr_q;
      if (update_btb) ghr_d = {ghr_q[2:0], branch_outcome};
   end

   always_ff @(posedge CLK) begin
      if (RST) ghr_q <= 4'd0;
      else     ghr_q <= ghr_d;
   end
`else
   assign f_pidx = f_idx;
   assign u_pidx = u_idx;
`endif

   assign f_hit = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
   assign u_hit = btb_valid_q[u_idx] && (btb_tag_q[u_idx] == u_tag);
   assign u_cnt = pht_q[u_pidx];

   always_comb begin
      u_cnt_d = u_cnt;
      if (branch_outcome) begin
         if (u_cnt != 2'd3) u_cnt_d = u_cnt + 2'd1;
      end else begin
         if (u_cnt != 2'd0) u_cnt_d = u_cnt - 2'd1;
      end
   end

   always_comb begin
      pred_valid_d = fetch_valid;
      pred_hit_d   = fetch_valid && f_hit;
      pred_out_d   = pred_hit_d && pht_q[f_pidx][1];
      pred_tgt_d   = pred_hit_d ? btb_tgt_q[f_idx] : 32'd0;
      miss_count_d = miss_count_q;
      if (update_btb && miss && (miss_count_q != 16'hFFFF))
         miss_count_d = miss_count_q + 16'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pred_valid_q <= 1'b0;
         pred_hit_q   <= 1'b0;
         pred_out_q   <= 1'b0;
         pred_tgt_q   <= 32'd0;
         miss_count_q <= 16'd0;
      end else begin
         pred_valid_q <= pred_valid_d;
         pred_hit_q   <= pred_hit_d;
         pred_out_q   <= pred_out_d;
         pred_tgt_q   <= pred_tgt_d;
         miss_count_q <= miss_count_d;
      end
   end

   // Valid bits and counters; table reads above see these pre-update values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_valid_q[i] <= 1'b0;
            pht_q[i]       <= 2'd1;
         end
      end else if (update_btb) begin
         if (u_hit) begin
            pht_q[u_pidx] <= u_cnt_d;
         end else if (branch_outcome) begin
            btb_valid_q[u_idx] <= 1'b1;
            pht_q[u_pidx]      <= 2'd2;
         end
      end
   end

   // Tag/target storage is never cleared; valid bits gate its use.
   always_ff @(posedge CLK) begin
      if (!RST && update_btb && branch_outcome) begin
         btb_tgt_q[u_idx] <= branch_target;
         if (!u_hit) btb_tag_q[u_idx] <= u_tag;
      end
   end

   assign pred_valid        = pred_valid_q;
   assign pred_hit          = pred_hit_q;
   assign predicted_outcome = pred_out_q;
   assign predicted_target  = pred_tgt_q;
   assign miss_count        = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor (default build)
module tb_branch_predictor;

   logic        CLK = 1'b0;
   logic        RST;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        pred_valid;
   logic        predicted_outcome;
   logic [31:0] predicted_target;
   logic        pred_hit;
   logic        update_btb;
   logic [31:0] update_pc;
   logic        branch_outcome;
   logic [31:0] branch_target;
   logic        miss;
   logic [15:0] miss_count;

   int vectors = 0;
   int miscompares = 0;

   branch_predictor #(.ENTRIES(16)) dut (
      .CLK(CLK), .RST(RST),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
      .pred_valid(pred_valid), .predicted_outcome(predicted_outcome),
      .predicted_target(predicted_target), .pred_hit(pred_hit),
      .update_btb(update_btb), .update_pc(update_pc),
      .branch_outcome(branch_outcome), .branch_target(branch_target),
      .miss(miss), .miss_count(miss_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      fetch_valid = 1'b0; fetch_pc = 32'd0;
      update_btb = 1'b0; update_pc = 32'd0;
      branch_outcome = 1'b0; branch_target = 32'd0; miss = 1'b0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic ms);
      idle();
      update_btb = 1'b1; update_pc = pc; branch_outcome = tk;
      branch_target = tgt; miss = ms;
      cyc();
      idle();
   endtask

   task automatic fchk(input string tag, input logic [31:0] pc, input logic eh,
                       input logic eo, input logic [31:0] et);
      idle();
      fetch_valid = 1'b1; fetch_pc = pc;
      cyc();
      idle();
      check({tag, ".valid"}, {31'd0, pred_valid}, 32'd1);
      check({tag, ".hit"}, {31'd0, pred_hit}, {31'd0, eh});
      check({tag, ".outcome"}, {31'd0, predicted_outcome}, {31'd0, eo});
      check({tag, ".target"}, predicted_target, et);
   endtask

   initial begin
      // Reset cycle with concurrent fetch and update must be overridden
      idle();
      RST = 1'b1;
      fetch_valid = 1'b1; fetch_pc = 32'h100;
      update_btb = 1'b1; update_pc = 32'h100; branch_outcome = 1'b1;
      branch_target = 32'h200; miss = 1'b1;
      cyc();
      check("rst.valid", {31'd0, pred_valid}, 32'd0);
      check("rst.hit", {31'd0, pred_hit}, 32'd0);
      check("rst.outcome", {31'd0, predicted_outcome}, 32'd0);
      check("rst.target", predicted_target, 32'd0);
      check("rst.miss_count", {16'd0, miss_count}, 32'd0);
      RST = 1'b0;
      idle();
      cyc();
      check("idle.valid", {31'd0, pred_valid}, 32'd0);

      fchk("cold", 32'h100, 1'b0, 1'b0, 32'd0);

      upd(32'h100, 1'b1, 32'h200, 1'b0);
      fchk("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

      // Counter 2 -> 1 -> 0 -> 0; not-taken updates keep the target
      upd(32'h100, 1'b0, 32'h999, 1'b0);
      fchk("nt1", 32'h100, 1'b1, 1'b0, 32'h200);
      upd(32'h100, 1'b0, 32'h999, 1'b0);
      fchk("nt2", 32'h100, 1'b1, 1'b0, 32'h200);
      upd(32'h100, 1'b0, 32'h999, 1'b0);
      fchk("nt3", 32'h100, 1'b1, 1'b0, 32'h200);
      // 0 -> 1 (still not taken), target overwritten on taken hit
      upd(32'h100, 1'b1, 32'h300, 1'b0);
      fchk("t_from0", 32'h100, 1'b1, 1'b0, 32'h300);
      // 1 -> 2 -> 3 -> 3, then 3 -> 2 stays taken
      upd(32'h100, 1'b1, 32'h300, 1'b0);
      upd(32'h100, 1'b1, 32'h300, 1'b0);
      upd(32'h100, 1'b1, 32'h300, 1'b0);
      upd(32'h100, 1'b0, 32'h999, 1'b0);
      fchk("sat3", 32'h100, 1'b1, 1'b1, 32'h300);

      // Alias at index 0 replaces 0x100
      upd(32'h140, 1'b1, 32'h444, 1'b0);
      fchk("alias_old", 32'h100, 1'b0, 1'b0, 32'd0);
      fchk("alias_new", 32'h140, 1'b1, 1'b1, 32'h444);

      // Not-taken miss allocates nothing and leaves the occupant alone
      upd(32'h500, 1'b0, 32'h555, 1'b0);
      fchk("ntmiss", 32'h500, 1'b0, 1'b0, 32'd0);
      fchk("ntmiss_keep", 32'h140, 1'b1, 1'b1, 32'h444);
      fchk("lowbits", 32'h143, 1'b1, 1'b1, 32'h444);

      // update_btb low: other update inputs ignored
      idle();
      update_pc = 32'h140; branch_outcome = 1'b0; branch_target = 32'h777; miss = 1'b1;
      cyc();
      idle();
      check("noupd.miss_count", {16'd0, miss_count}, 32'd0);
      fchk("noupd", 32'h140, 1'b1, 1'b1, 32'h444);

      // Same-cycle fetch and update: no bypass
      idle();
      fetch_valid = 1'b1; fetch_pc = 32'h180;
      update_btb = 1'b1; update_pc = 32'h180; branch_outcome = 1'b1; branch_target = 32'h888;
      cyc();
      idle();
      check("same.hit", {31'd0, pred_hit}, 32'd0);
      check("same.target", predicted_target, 32'd0);
      fchk("same_next", 32'h180, 1'b1, 1'b1, 32'h888);
      cyc();
      check("nofetch.valid", {31'd0, pred_valid}, 32'd0);
      check("nofetch.hit", {31'd0, pred_hit}, 32'd0);
      check("nofetch.target", predicted_target, 32'd0);

      // miss_count saturation
      upd(32'h700, 1'b0, 32'd0, 1'b1);
      check("mc.one", {16'd0, miss_count}, 32'd1);
      for (int i = 1; i < 65534; i++) upd(32'h700, 1'b0, 32'd0, 1'b1);
      check("mc.fffe", {16'd0, miss_count}, 32'hFFFE);
      for (int i = 0; i < 6; i++) upd(32'h700, 1'b0, 32'd0, 1'b1);
      check("mc.sat", {16'd0, miss_count}, 32'hFFFF);
      fchk("mc.table", 32'h180, 1'b1, 1'b1, 32'h888);

      RST = 1'b1;
      cyc();
      RST = 1'b0;
      check("rst2.miss_count", {16'd0, miss_count}, 32'd0);
      fchk("rst2.cleared", 32'h180, 1'b0, 1'b0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL take parameter ENTRIES, default 16, giving the number of BTB and PHT entries (power of two, 4..256).
REQ-002 The block SHALL derive IDX_W = log2(ENTRIES) and TAG_W = 30 - IDX_W internally; neither is a port parameter.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 fetch_valid  input  1  lookup request this cycle.
REQ-006 fetch_pc  input  32  PC to predict.
REQ-007 pred_valid  output  1  prediction outputs are valid.
REQ-008 predicted_outcome  output  1  1 = predict taken.
REQ-009 predicted_target  output  32  BTB target; 0 when no hit.
REQ-010 pred_hit  output  1  BTB entry valid and tag matched.
REQ-011 update_btb  input  1  resolution update strobe from the branch unit.
REQ-012 update_pc  input  32  PC of the resolved branch.
REQ-013 branch_outcome  input  1  actual direction (1 = taken).
REQ-014 branch_target  input  32  actual taken target.
REQ-015 miss  input  1  resolved direction differed from the prediction.
REQ-016 miss_count  output  16  saturating count of mispredicted updates.

Function
REQ-017 Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-018 BTB entry = {valid, tag, target}; PHT entry = 2-bit saturating counter, separate array.
REQ-019 Lookup latency SHALL be 1 cycle: pred_valid at cycle N+1 = fetch_valid at cycle N; outputs registered.
REQ-020 pred_hit = valid && tag match; predicted_outcome = pred_hit && PHT[pidx][1]; predicted_target = BTB target on hit, else 0.
REQ-021 When fetch_valid = 0, next-cycle pred_valid, pred_hit, predicted_outcome SHALL be 0 and predicted_target SHALL be 0.
REQ-022 On update_btb with BTB hit: the PHT counter SHALL increment if branch_outcome = 1 and decrement otherwise, saturating at 3 and 0; the target SHALL be overwritten with branch_target only when taken.
REQ-023 On update_btb with BTB miss and branch_outcome = 1: the block SHALL allocate the entry (valid = 1, tag, target = branch_target) and set the PHT counter to 2, replacing any previous occupant.
REQ-024 On update_btb with BTB miss and branch_outcome = 0: there SHALL be no BTB or PHT change.
REQ-025 Simultaneous lookup and update at the same index: the lookup SHALL return pre-update contents (no bypass); the update SHALL take effect for lookups issued from the next cycle.
REQ-026 miss_count SHALL increment by 1 on each cycle with update_btb && miss, and SHALL hold at 16'hFFFF.
REQ-027 update_btb = 0 SHALL leave all table state, GHR and miss_count unchanged regardless of the other update inputs.

Reset
REQ-028 While RST = 1 at a clock edge: all BTB valid bits = 0, all PHT counters = 1 (weakly not-taken), GHR = 0, miss_count = 0, pred_valid/pred_hit/predicted_outcome = 0, predicted_target = 0.
REQ-029 Reset SHALL override any concurrent fetch_valid or update_btb in the same cycle; a lookup issued in a reset cycle produces no prediction.
REQ-030 BTB tag and target storage need not be cleared by reset.

Configuration
REQ-031 Macro BP_GSHARE_EN defined: a 4-bit GHR (reset 0) SHALL shift left, inserting branch_outcome at bit 0, on each update_btb. The PHT index SHALL be index XOR zero-extended GHR (truncated to IDX_W). The BTB index SHALL stay the plain index.
REQ-032 Macro BP_GSHARE_EN undefined: there SHALL be no GHR, and the PHT index SHALL equal the BTB index.
REQ-033 Under BP_GSHARE_EN, lookup and update in the same cycle SHALL both use the pre-shift GHR.

Verification
REQ-034 Reset, then fetch 0x100 -> next cycle pred_valid = 1, pred_hit = 0, predicted_outcome = 0, predicted_target = 0.
REQ-035 Update pc 0x100, taken, target 0x200; then fetch 0x100 -> pred_hit = 1, predicted_outcome = 1, predicted_target = 0x200.
REQ-036 Three not-taken updates on 0x100 after allocation -> counter 2->1->0->0, predicted_outcome = 0, pred_hit still 1.
REQ-037 Alias: allocate 0x100, then taken update 0x140 (ENTRIES = 16) -> fetch 0x100 misses; fetch 0x140 hits with the new target.
REQ-038 Same-cycle fetch and taken update of 0x180 -> that lookup sees pred_hit = 0; a fetch one cycle later sees pred_hit = 1.
REQ-039 Drive 65540 update_btb cycles with miss = 1 -> miss_count = 0xFFFF; assert RST -> miss_count = 0 the next cycle.
